mac_tile_engine: RTL and testbench

- Parametrised successor to the existing NxN MAC grid.
- Rectangular ROWS x COLS array of multiply-accumulate cells.
- Adds an internal sequencer: a k_len-deep accumulate loop with a valid/ready input stream, a signed/unsigned mode, optional saturation with a sticky overflow flag, and a row-by-row valid/ready result drain.
- Sits between the operand fetch path and the writeback path of the accelerator.

---
 rtl/mac_tile_engine_if.sv | 39 +++
 rtl/mac_tile_engine.sv | 176 +++++++++++++++++
 tb/tb_mac_tile_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tile_engine_if.sv
// Operand, result and status bundle for mac_tile_engine.
// The slave modport is the engine side; the master modport is the driver side.
interface mac_tile_engine_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 256
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                       start;
  logic [KW-1:0]              k_len;
  logic                       signed_mode;
  logic                       sat_en;
  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*DATA_WIDTH-1:0] a_vec;
  logic [COLS*DATA_WIDTH-1:0] b_vec;
  logic                       out_valid;
  logic                       out_ready;
  logic [COLS*ACC_WIDTH-1:0]  out_data;
  logic [RW-1:0]              out_row;
  logic                       out_last;
  logic                       busy;
  logic                       done;
  logic                       overflow;

  modport slave (
    input  start, k_len, signed_mode, sat_en, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last, busy, done, overflow
  );

  modport master (
    output start, k_len, signed_mode, sat_en, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last, busy, done, overflow
  );
endinterface

// File: rtl/mac_tile_engine.sv
// ROWS x COLS multiply-accumulate tile with a k_len-deep load loop, optional
// saturation with sticky overflow, and a row-by-row valid/ready result drain.
module mac_tile_engine #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 256
) (
  input logic              clk,
  input logic              rst,
  mac_tile_engine_if.slave bus
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int XW = ACC_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_len_q, k_len_d;
  logic [KW-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 signed_q, signed_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] acc_q [ROWS][COLS];
  logic [ACC_WIDTH-1:0] acc_d [ROWS][COLS];

  logic [ACC_WIDTH-1:0] mac_res [ROWS][COLS];
  logic                 mac_ovf [ROWS][COLS];
  logic                 ovf_any;
  logic                 accept;
  logic [KW:0]          cnt_inc;

  // Returns {overflow, next accumulator}; the sum is formed one bit wider
  // than the accumulator so both signed and unsigned range escapes are visible.
  function automatic logic [XW-1:0] mac_step(
    input logic [ACC_WIDTH-1:0]  acc,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  sm,
    input logic                  se
  );
    logic [PW-1:0]        prod;
    logic [XW-1:0]        prod_x;
    logic [XW-1:0]        acc_x;
    logic [XW-1:0]        sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] res;
    if (sm) begin
      prod   = $signed(a) * $signed(b);
      prod_x = {{(XW-PW){prod[PW-1]}}, prod};
      acc_x  = {acc[ACC_WIDTH-1], acc};
    end else begin
      prod   = a * b;
      prod_x = {{(XW-PW){1'b0}}, prod};
      acc_x  = {1'b0, acc};
    end
    sum = acc_x + prod_x;
    ovf = sm ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    res = sum[ACC_WIDTH-1:0];
    if (ovf && se) begin
      if (!sm)                res = '1;
      else if (sum[ACC_WIDTH]) res = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                    res = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return {ovf, res};
  endfunction

  always_comb begin
    logic [XW-1:0] r;
    r       = '0;
    ovf_any = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        r = mac_step(acc_q[i][j], bus.a_vec[i*DATA_WIDTH +: DATA_WIDTH],
                     bus.b_vec[j*DATA_WIDTH +: DATA_WIDTH], signed_q, sat_q);
        mac_res[i][j] = r[ACC_WIDTH-1:0];
        mac_ovf[i][j] = r[ACC_WIDTH];
        ovf_any       = ovf_any | r[ACC_WIDTH];
      end
    end
  end

  assign accept  = (state_q == LOAD) && bus.in_valid;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_len_d  = bus.k_len;
          signed_d = bus.signed_mode;
          sat_d    = bus.sat_en;
          cnt_d    = '0;
          row_d    = '0;
          ovf_d    = 1'b0;
          for (int unsigned i = 0; i < ROWS; i++)
            for (int unsigned j = 0; j < COLS; j++)
              acc_d[i][j] = '0;
          state_d = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          acc_d = mac_res;
          if (ovf_any) ovf_d = 1'b1;
          if (cnt_inc == {1'b0, k_len_q}) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_inc[KW-1:0];
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      signed_q <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      signed_q <= signed_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned j = 0; j < COLS; j++)
      bus.out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_row   = row_q;
  assign bus.out_last  = (state_q == DRAIN) && (row_q == RW'(ROWS - 1));
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mac_tile_engine.sv
// Directed bench for mac_tile_engine: a 32-bit accumulator instance for the
// main job flow and a 16-bit instance for saturation/wrap behaviour.
module tb_mac_tile_engine;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_c [4][4];

  mac_tile_engine_if #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .K_MAX(256)) bus ();
  mac_tile_engine_if #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .K_MAX(256)) bus16 ();

  mac_tile_engine #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .K_MAX(256)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mac_tile_engine #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .K_MAX(256)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [8:0] k, input logic sm, input logic se);
    bus.k_len       = k;
    bus.signed_mode = sm;
    bus.sat_en      = se;
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
    bus.k_len       = 9'd7;
    bus.signed_mode = ~sm;
    bus.sat_en      = ~se;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    bus.a_vec    = a;
    bus.b_vec    = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_exp(input logic [31:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_c[i][j] = v;
  endtask

  // Drains rows first_row..3 with out_ready high, then checks the done pulse.
  task automatic drain_rows(input string tag, input int first_row);
    bus.out_ready = 1'b1;
    for (int r = first_row; r < 4; r++) begin
      check($sformatf("%s_valid_r%0d", tag, r), 64'(bus.out_valid), 64'd1);
      check($sformatf("%s_row_r%0d", tag, r), 64'(bus.out_row), 64'(r));
      check($sformatf("%s_last_r%0d", tag, r), 64'(bus.out_last), 64'(r == 3));
      for (int j = 0; j < 4; j++)
        check($sformatf("%s_c%0d%0d", tag, r, j), 64'(bus.out_data[j*32 +: 32]), 64'(exp_c[r][j]));
      step();
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_done_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_done_valid"}, 64'(bus.out_valid), 64'd0);
    step();
    check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.k_len = '0; bus.signed_mode = 1'b0; bus.sat_en = 1'b0;
    bus.in_valid = 1'b0; bus.a_vec = '0; bus.b_vec = '0; bus.out_ready = 1'b1;
    bus16.start = 1'b0; bus16.k_len = '0; bus16.signed_mode = 1'b0; bus16.sat_en = 1'b0;
    bus16.in_valid = 1'b0; bus16.a_vec = '0; bus16.b_vec = '0; bus16.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_out_row", 64'(bus.out_row), 64'd0);

    // Unsigned, k_len=2, a=1, b=2: every element 1*2 + 1*2 = 4.
    start_job(9'd2, 1'b0, 1'b0);
    check("basic_in_ready", 64'(bus.in_ready), 64'd1);
    check("basic_busy", 64'(bus.busy), 64'd1);
    beat({4{8'd1}}, {4{8'd2}});
    check("basic_mid_valid", 64'(bus.out_valid), 64'd0);
    beat({4{8'd1}}, {4{8'd2}});
    set_exp(32'd4);
    drain_rows("basic", 0);
    check("basic_overflow", 64'(bus.overflow), 64'd0);

    // -128 * -128 signed and 128 * 128 unsigned both give 16384.
    start_job(9'd1, 1'b1, 1'b0);
    beat(32'h0000_0080, 32'h0000_0080);
    set_exp(32'd0);
    exp_c[0][0] = 32'd16384;
    drain_rows("s80", 0);
    start_job(9'd1, 1'b0, 1'b0);
    beat(32'h0000_0080, 32'h0000_0080);
    drain_rows("u80", 0);

    // 0xFF * 0x02: -1 * 2 signed, 255 * 2 unsigned.
    start_job(9'd1, 1'b1, 1'b0);
    beat(32'h0000_00FF, 32'h0000_0002);
    exp_c[0][0] = 32'hFFFF_FFFE;
    drain_rows("sff", 0);
    check("sff_overflow", 64'(bus.overflow), 64'd0);
    start_job(9'd1, 1'b0, 1'b0);
    beat(32'h0000_00FF, 32'h0000_0002);
    exp_c[0][0] = 32'd510;
    drain_rows("uff", 0);

    // 16-bit accumulator, signed, 3 x 127*127 = 48387: saturate then wrap.
    for (int m = 0; m < 2; m++) begin
      bus16.k_len = 9'd3;
      bus16.signed_mode = 1'b1;
      bus16.sat_en = (m == 0);
      bus16.start = 1'b1;
      step();
      bus16.start = 1'b0;
      bus16.a_vec = {4{8'd127}};
      bus16.b_vec = {4{8'd127}};
      bus16.in_valid = 1'b1;
      step();
      step();
      step();
      bus16.in_valid = 1'b0;
      for (int r = 0; r < 4; r++) begin
        check($sformatf("acc16_m%0d_valid_r%0d", m, r), 64'(bus16.out_valid), 64'd1);
        for (int j = 0; j < 4; j++)
          check($sformatf("acc16_m%0d_c%0d%0d", m, r, j), 64'(bus16.out_data[j*16 +: 16]),
                (m == 0) ? 64'h7FFF : 64'hBD03);
        step();
      end
      check($sformatf("acc16_m%0d_done", m), 64'(bus16.done), 64'd1);
      check($sformatf("acc16_m%0d_overflow", m), 64'(bus16.overflow), 64'd1);
      step();
    end

    // Gapped input stream, stalled drain on row 1, start pulsed while draining.
    bus.out_ready = 1'b0;
    start_job(9'd2, 1'b0, 1'b0);
    bus.a_vec = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.b_vec = {4{8'd1}};
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check("bp_gap_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_gap_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_c[i][j] = 32'(2 * (i + 1));
    check("bp_r0_valid", 64'(bus.out_valid), 64'd1);
    check("bp_r0_row", 64'(bus.out_row), 64'd0);
    check("bp_r0_c00", 64'(bus.out_data[31:0]), 64'd2);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check($sformatf("bp_hold%0d_row", h), 64'(bus.out_row), 64'd1);
      check($sformatf("bp_hold%0d_valid", h), 64'(bus.out_valid), 64'd1);
      for (int j = 0; j < 4; j++)
        check($sformatf("bp_hold%0d_c1%0d", h, j), 64'(bus.out_data[j*32 +: 32]), 64'd4);
      if (h == 1) begin
        bus.k_len = 9'd1;
        bus.start = 1'b1;
      end
      step();
      bus.start = 1'b0;
    end
    drain_rows("bp", 1);
    step();
    check("bp_start_ignored", 64'(bus.busy), 64'd0);

    // k_len=0 skips LOAD and drains zeros over the previous job's results.
    start_job(9'd0, 1'b0, 1'b0);
    check("k0_in_ready", 64'(bus.in_ready), 64'd0);
    set_exp(32'd0);
    drain_rows("k0", 0);

    // Reset mid-LOAD, then a fresh job must show no residue.
    start_job(9'd4, 1'b0, 1'b0);
    beat({4{8'd1}}, {4{8'd1}});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_out_last", 64'(bus.out_last), 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_done", 64'(bus.done), 64'd0);
    check("mrst_out_row", 64'(bus.out_row), 64'd0);
    check("mrst_overflow", 64'(bus.overflow), 64'd0);
    check("mrst_overflow16", 64'(bus16.overflow), 64'd0);
    start_job(9'd1, 1'b0, 1'b0);
    beat({4{8'd3}}, {4{8'd5}});
    set_exp(32'd15);
    drain_rows("post", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
